manual_ctrl_input: RTL and testbench

- Front-end for the traffic light controller's manual-control inputs.
- Synchronizes and debounces two raw push buttons (mode, next), detects presses, and runs a small mode FSM.
- Drives the controller's manual_override and manual_state inputs directly; all outputs are registered.

---
 rtl/manual_ctrl_input.sv | 144 ++++++++++++++
 tb/tb_manual_ctrl_input.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/manual_ctrl_input.sv
// rtl/manual_ctrl_input.sv - button sync/debounce/press-detect and manual mode FSM for the traffic light controller
// Optional feature macro: MANUAL_TIMEOUT_EN (inactivity auto-exit from manual mode)
module manual_ctrl_input #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_next,
    output logic       manual_override,
    output logic [1:0] manual_state,
    output logic       state_changed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_AUTO = 2'd0,
        ST_RED  = 2'd1,
        ST_YEL  = 2'd2,
        ST_GRN  = 2'd3
    } state_t;

    // Bit 0 carries the mode button, bit 1 the next button.
    logic [1:0]    w_btn;
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_deb;
    logic [1:0]    r_deb_prev;
    logic [1:0]    r_press;
    logic [CW-1:0] r_cnt [2];

    state_t        r_state;
    state_t        w_next;
    logic          w_press_mode;
    logic          w_press_next;
    logic          w_timeout;

    assign w_btn        = {btn_next, btn_mode};
    assign w_press_mode = r_press[0];
    assign w_press_next = r_press[1];

    // The press pulse is registered so every output change lands on a fixed
    // DEBOUNCE_CYCLES+3 edges after the raw button is first sampled high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_deb      <= '0;
            r_deb_prev <= '0;
            r_press    <= '0;
            r_cnt[0]   <= '0;
            r_cnt[1]   <= '0;
        end else begin
            r_sync1    <= w_btn;
            r_sync2    <= r_sync1;
            r_deb_prev <= r_deb;
            r_press    <= r_deb & ~r_deb_prev;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_cnt[i] == DEB_MAX) begin
                        r_deb[i] <= ~r_deb[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

`ifdef MANUAL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_idle;

    // A pending press always wins over the timeout on the same edge.
    assign w_timeout = (r_state != ST_AUTO) && !(|r_press) && (r_idle == IDLE_MAX);

    always_ff @(posedge clk) begin
        if (reset || (r_state == ST_AUTO) || (|r_press)) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_AUTO: begin
                if (w_press_mode) begin
                    w_next = ST_RED;
                end
            end
            default: begin
                if (w_press_mode) begin
                    w_next = ST_AUTO;
                end else if (w_press_next) begin
                    case (r_state)
                        ST_RED:  w_next = ST_GRN;
                        ST_GRN:  w_next = ST_YEL;
                        default: w_next = ST_RED;
                    endcase
                end
                if (w_timeout) begin
                    w_next = ST_AUTO;
                end
            end
        endcase
    end

    function automatic logic [1:0] encode_state(input state_t s);
        case (s)
            ST_YEL:  encode_state = 2'b01;
            ST_GRN:  encode_state = 2'b10;
            default: encode_state = 2'b00;
        endcase
    endfunction

    // Outputs follow the next state so they change on the same edge as r_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_AUTO;
            manual_override <= 1'b0;
            manual_state    <= 2'b00;
            state_changed   <= 1'b0;
        end else begin
            r_state         <= w_next;
            manual_override <= (w_next != ST_AUTO);
            manual_state    <= encode_state(w_next);
            state_changed   <= (w_next != r_state);
        end
    end

endmodule

// File: tb/tb_manual_ctrl_input.sv
// tb/tb_manual_ctrl_input.sv - self-checking bench for manual_ctrl_input
module tb_manual_ctrl_input;

    localparam int DEB = 4;
    localparam int TMO = 64;
    localparam int LAT = DEB + 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_next = 1'b0;
    logic       manual_override;
    logic [1:0] manual_state;
    logic       state_changed;

    typedef struct packed {
        logic       ovr;
        logic [1:0] st;
    } exp_t;

    exp_t q_exp[$];
    int   n_total = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   last_change = -1;

    manual_ctrl_input #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_mode       (btn_mode),
        .btn_next       (btn_next),
        .manual_override(manual_override),
        .manual_state   (manual_state),
        .state_changed  (state_changed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag);
        exp_t e;
        if (q_exp.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = q_exp.pop_front();
            check({tag, "_ovr"}, manual_override, e.ovr);
            check({tag, "_st"}, manual_state, e.st);
        end
    endtask

    // Holds the given buttons for 'hold' sampled cycles, then releases and lets
    // the release settle; counts state_changed pulses and the edge of the first one.
    task automatic drive(input logic m, input logic n, input int hold,
                         output int first, output int pulses);
        btn_mode = m;
        btn_next = n;
        first = -1;
        pulses = 0;
        for (int c = 0; c < hold + 16; c++) begin
            @(negedge clk);
            if (state_changed) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    last_change = cyc;
                end
            end
            if (c == hold - 1) begin
                btn_mode = 1'b0;
                btn_next = 1'b0;
            end
        end
    endtask

    task automatic press(input string tag, input logic m, input logic n, input int hold,
                         input logic eo, input logic [1:0] es, input int exp_pulses);
        int first;
        int pulses;
        q_exp.push_back('{ovr: eo, st: es});
        drive(m, n, hold, first, pulses);
        check({tag, "_pulses"}, pulses, exp_pulses);
        if (exp_pulses > 0) check({tag, "_latency"}, first, LAT);
        check_outputs(tag);
    endtask

    task automatic wait_change(input int budget, output int at);
        at = -1;
        for (int c = 0; c < budget && at < 0; c++) begin
            @(negedge clk);
            if (state_changed) at = cyc;
        end
    endtask

    initial begin
        int first;
        int pulses;
        int entry;
        int at;

        repeat (2) @(negedge clk);
        check("rst_ovr", manual_override, 1'b0);
        check("rst_st", manual_state, 2'b00);
        check("rst_sc", state_changed, 1'b0);
        reset = 1'b0;

        press("idle", 1'b0, 1'b0, 34, 1'b0, 2'b00, 0);

        press("mode_on", 1'b1, 1'b0, 10, 1'b1, 2'b00, 1);
        press("mode_off", 1'b1, 1'b0, 10, 1'b0, 2'b00, 1);
        press("next_auto", 1'b0, 1'b1, 10, 1'b0, 2'b00, 0);

        press("mode_on2", 1'b1, 1'b0, 10, 1'b1, 2'b00, 1);
        press("next_grn", 1'b0, 1'b1, 10, 1'b1, 2'b10, 1);
        press("next_yel", 1'b0, 1'b1, 10, 1'b1, 2'b01, 1);
        press("next_red", 1'b0, 1'b1, 10, 1'b1, 2'b00, 1);
        press("mode_off2", 1'b1, 1'b0, 10, 1'b0, 2'b00, 1);

        press("glitch", 1'b1, 1'b0, DEB - 1, 1'b0, 2'b00, 0);

        for (int i = 0; i < 4; i++) begin
            btn_mode = (i % 2 == 0);
            @(negedge clk);
            check("bounce_quiet", state_changed, 1'b0);
        end
        press("bounce", 1'b1, 1'b0, 10, 1'b1, 2'b00, 1);

        press("to_grn", 1'b0, 1'b1, 10, 1'b1, 2'b10, 1);
        press("simul", 1'b1, 1'b1, 10, 1'b0, 2'b00, 1);

        press("mode_on3", 1'b1, 1'b0, 10, 1'b1, 2'b00, 1);
        press("to_grn2", 1'b0, 1'b1, 10, 1'b1, 2'b10, 1);
        press("to_yel", 1'b0, 1'b1, 10, 1'b1, 2'b01, 1);
        reset = 1'b1;
        q_exp.push_back('{ovr: 1'b0, st: 2'b00});
        @(negedge clk);
        check_outputs("mid_rst");
        check("mid_rst_sc", state_changed, 1'b0);
        reset = 1'b0;
        press("after_rst", 1'b1, 1'b0, 10, 1'b1, 2'b00, 1);
        press("after_rst_off", 1'b1, 1'b0, 10, 1'b0, 2'b00, 1);

`ifdef MANUAL_TIMEOUT_EN
        press("tmo_enter", 1'b1, 1'b0, 10, 1'b1, 2'b00, 1);
        entry = last_change;
        q_exp.push_back('{ovr: 1'b0, st: 2'b00});
        wait_change(200, at);
        check("tmo_delay", at - entry, TMO);
        check_outputs("tmo_exit");

        press("tmo_enter2", 1'b1, 1'b0, 10, 1'b1, 2'b00, 1);
        entry = last_change;
        while (cyc < entry + 32) @(negedge clk);
        press("tmo_next", 1'b0, 1'b1, 10, 1'b1, 2'b10, 1);
        entry = last_change;
        q_exp.push_back('{ovr: 1'b0, st: 2'b00});
        wait_change(200, at);
        check("tmo_restart", at - entry, TMO);
        check_outputs("tmo_exit2");
`else
        drive(1'b0, 1'b0, 1, first, pulses);
        entry = first;
        at = pulses;
        check("no_tmo_pulses", at, 0);
        check("no_tmo_first", entry, -1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
